// File: rtl/apb_controller.sv
// AHB-to-APB bridge state machine: turns the AHB slave's decoded, pipelined
// transfer information into APB setup/enable phases and returns ready/data.
module apb_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              Valid,
    input  logic              Hwrite,
    input  logic              Hwrite_reg,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hdata1,
    input  logic [NSLV-1:0]   Tempselx,
    input  logic [DATA_W-1:0] Prdata,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WRITEP,
        ST_WENABLE,
        ST_WENABLEP,
        ST_READ,
        ST_RENABLE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [NSLV-1:0]   r_psel, w_psel_nxt;
    logic [NSLV-1:0]   r_sel_wwait, w_sel_wwait_nxt;
    logic [NSLV-1:0]   r_tempsel_d;
    logic              r_penable, w_penable_nxt;
    logic              r_pwrite, w_pwrite_nxt;
    logic              r_hready, w_hready_nxt;
    logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
    logic              w_mapped;
    logic              w_valid;

    // A transfer with no peripheral selected is unmapped and never starts a setup.
    assign w_mapped = |Tempselx;
    assign w_valid  = Valid && w_mapped;

    always_comb begin
        w_state_nxt     = r_state;
        w_psel_nxt      = r_psel;
        w_sel_wwait_nxt = r_sel_wwait;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;

        case (r_state)
            ST_IDLE, ST_WENABLE, ST_RENABLE: begin
                w_psel_nxt  = '0;
                w_state_nxt = ST_IDLE;
                if (w_valid && !Hwrite) begin
                    w_state_nxt  = ST_READ;
                    w_paddr_nxt  = Haddr;
                    w_pwrite_nxt = 1'b0;
                    w_psel_nxt   = Tempselx;
                end else if (w_valid && Hwrite) begin
                    w_state_nxt     = ST_WWAIT;
                    w_sel_wwait_nxt = Tempselx;
                end
            end
            ST_WWAIT: begin
                w_state_nxt  = w_valid ? ST_WRITEP : ST_WRITE;
                w_paddr_nxt  = Haddr1;
                w_pwdata_nxt = Hwdata;
                w_pwrite_nxt = 1'b1;
                w_psel_nxt   = r_sel_wwait;
            end
            ST_WRITE:  w_state_nxt = ST_WENABLE;
            ST_WRITEP: w_state_nxt = ST_WENABLEP;
            ST_READ:   w_state_nxt = ST_RENABLE;
            ST_WENABLEP: begin
                // The queued write's address/data are now two/one cycles old;
                // a missing select abandons it rather than issue an unselected setup.
                w_psel_nxt  = '0;
                w_state_nxt = ST_IDLE;
                if (!Hwrite_reg) begin
                    if (w_mapped) begin
                        w_state_nxt  = ST_READ;
                        w_paddr_nxt  = Haddr;
                        w_pwrite_nxt = 1'b0;
                        w_psel_nxt   = Tempselx;
                    end
                end else if (|r_tempsel_d) begin
                    w_state_nxt  = w_valid ? ST_WRITEP : ST_WRITE;
                    w_paddr_nxt  = Haddr2;
                    w_pwdata_nxt = Hdata1;
                    w_pwrite_nxt = 1'b1;
                    w_psel_nxt   = r_tempsel_d;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_psel_nxt  = '0;
            end
        endcase

        w_penable_nxt = 1'b0;
        w_hready_nxt  = 1'b1;
        case (w_state_nxt)
            ST_WENABLE, ST_WENABLEP, ST_RENABLE: w_penable_nxt = 1'b1;
            ST_WRITE, ST_WRITEP, ST_READ:        w_hready_nxt  = 1'b0;
            default: begin
                w_penable_nxt = 1'b0;
                w_hready_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= ST_IDLE;
            r_psel      <= '0;
            r_sel_wwait <= '0;
            r_tempsel_d <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_hready    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= w_psel_nxt;
            r_sel_wwait <= w_sel_wwait_nxt;
            r_tempsel_d <= Tempselx;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_hready    <= w_hready_nxt;
        end
    end

    assign Pselx     = r_psel;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Hreadyout = r_hready;
    assign Hrdata    = Prdata;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: directed vector table, random transaction
// scoreboard, and a random-traffic APB protocol checker.
module tb_apb_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;

    logic          Hclk;
    logic          Hreset, Valid, Hwrite, Hwrite_reg;
    logic [AW-1:0] Haddr, Haddr1, Haddr2, Paddr;
    logic [DW-1:0] Hwdata, Hdata1, Prdata, Pwdata, Hrdata;
    logic [NS-1:0] Tempselx, Pselx;
    logic          Penable, Pwrite, Hreadyout;

    apb_controller #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Valid(Valid), .Hwrite(Hwrite),
        .Hwrite_reg(Hwrite_reg), .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata(Hwdata), .Hdata1(Hdata1), .Tempselx(Tempselx), .Prdata(Prdata),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
        .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // AHB slave pipeline registers feeding the controller
    always @(posedge Hclk) begin
        Hwrite_reg <= Hwrite;
        Haddr1     <= Haddr;
        Haddr2     <= Haddr1;
        Hdata1     <= Hwdata;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic w, input logic [2:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        Hreset = rst; Valid = v; Hwrite = w; Tempselx = sel;
        Haddr = addr; Hwdata = wdata; Prdata = rdata;
    endtask

    task automatic cyc();
        @(posedge Hclk);
        #1;
    endtask

    typedef struct {
        logic        rst, v, w;
        logic [2:0]  sel;
        logic [31:0] addr, wdata, rdata;
        logic [2:0]  e_psel;
        logic        e_pen, e_pwr, e_rdy;
        logic [31:0] e_paddr, e_pwdata;
    } vec_t;
    vec_t vecs[$];

    task automatic av(input logic rst, input logic v, input logic w, input logic [2:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic [2:0] e_psel, input logic e_pen, input logic e_pwr, input logic e_rdy,
                      input logic [31:0] e_paddr, input logic [31:0] e_pwdata);
        vec_t t;
        t.rst = rst; t.v = v; t.w = w; t.sel = sel; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.e_psel = e_psel; t.e_pen = e_pen; t.e_pwr = e_pwr; t.e_rdy = e_rdy;
        t.e_paddr = e_paddr; t.e_pwdata = e_pwdata;
        vecs.push_back(t);
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] addr, data, rdata;
        logic        wr;
    } xfer_t;
    xfer_t exp_q[$];
    logic  mon_en = 1'b0;

    // Every APB enable phase must retire the oldest expected transfer
    always @(negedge Hclk) begin
        if (mon_en && Penable) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL apb_unexpected: got enable at addr 0x%0h expected none", Paddr);
            end else begin
                xfer_t t;
                t = exp_q.pop_front();
                check("apb_sel", Pselx, t.sel);
                check("apb_addr", Paddr, t.addr);
                check("apb_write", Pwrite, t.wr);
                if (t.wr) check("apb_wdata", Pwdata, t.data);
                else      check("apb_hrdata", Hrdata, t.rdata);
            end
        end
    end

    function automatic logic [2:0] rsel();
        logic [2:0] s;
        s = 3'b001 << $urandom_range(0, 2);
        return s;
    endfunction

    task automatic idle(input int unsigned n, input logic [31:0] rdata);
        for (int unsigned k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b0, 3'b000, $urandom, $urandom, rdata);
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time budget");
        $fatal(1);
    end

    initial begin
        logic [2:0]  s, s2, p_psel;
        logic [31:0] a, a2, d, d2, r, p_paddr, p_pwdata;
        logic        rst, p_pwrite, p_setup;
        xfer_t       x;

        // rst v w sel addr wdata rdata | psel pen pwr rdy paddr pwdata
        av(1,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,0,1,32'h0,32'h0);
        av(1,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,0,1,32'h0,32'h0);
        av(0,1,0,3'b001,32'h8000_0010,32'h0,32'hDEAD_BEEF, 3'b001,0,0,0,32'h8000_0010,32'h0);
        av(0,0,0,3'b000,32'h8000_0010,32'h0,32'hDEAD_BEEF, 3'b001,1,0,1,32'h8000_0010,32'h0);
        av(0,0,0,3'b000,32'h0,32'h0,32'hDEAD_BEEF,       3'b000,0,0,1,32'h8000_0010,32'h0);
        av(0,1,1,3'b010,32'h8400_0004,32'h0,32'h0,       3'b000,0,0,1,32'h8000_0010,32'h0);
        av(0,0,0,3'b000,32'h8400_0004,32'h1234_5678,32'h0, 3'b010,0,1,0,32'h8400_0004,32'h1234_5678);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b010,1,1,1,32'h8400_0004,32'h1234_5678);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,1,1,32'h8400_0004,32'h1234_5678);
        av(0,1,1,3'b100,32'h8800_0000,32'h0,32'h0,       3'b000,0,1,1,32'h8400_0004,32'h1234_5678);
        av(0,1,1,3'b100,32'h8800_0004,32'hA,32'h0,       3'b100,0,1,0,32'h8800_0000,32'hA);
        av(0,0,1,3'b100,32'h8800_0004,32'hB,32'h0,       3'b100,1,1,1,32'h8800_0000,32'hA);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b100,0,1,0,32'h8800_0004,32'hB);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b100,1,1,1,32'h8800_0004,32'hB);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,1,1,32'h8800_0004,32'hB);
        av(0,1,1,3'b001,32'h8C00_0008,32'h0,32'h0,       3'b000,0,1,1,32'h8800_0004,32'hB);
        av(0,0,0,3'b000,32'h0,32'h5555_AAAA,32'h0,       3'b001,0,1,0,32'h8C00_0008,32'h5555_AAAA);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b001,1,1,1,32'h8C00_0008,32'h5555_AAAA);
        av(0,1,0,3'b010,32'h9000_0020,32'h0,32'h0,       3'b010,0,0,0,32'h9000_0020,32'h5555_AAAA);
        av(0,0,0,3'b000,32'h0,32'h0,32'hCAFE_F00D,       3'b010,1,0,1,32'h9000_0020,32'h5555_AAAA);
        av(0,1,0,3'b001,32'h9000_0030,32'h0,32'h0,       3'b001,0,0,0,32'h9000_0030,32'h5555_AAAA);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b001,1,0,1,32'h9000_0030,32'h5555_AAAA);
        av(0,1,0,3'b000,32'h0000_1234,32'h0,32'h0,       3'b000,0,0,1,32'h9000_0030,32'h5555_AAAA);
        av(0,1,1,3'b000,32'h0000_1238,32'h0,32'h0,       3'b000,0,0,1,32'h9000_0030,32'h5555_AAAA);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,0,1,32'h9000_0030,32'h5555_AAAA);
        av(0,1,1,3'b010,32'hA000_0000,32'h0,32'h0,       3'b000,0,0,1,32'h9000_0030,32'h5555_AAAA);
        av(0,0,0,3'b000,32'h0,32'h77,32'h0,              3'b010,0,1,0,32'hA000_0000,32'h77);
        av(1,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,0,1,32'h0,32'h0);
        av(1,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,0,1,32'h0,32'h0);
        av(0,0,0,3'b000,32'h0,32'h0,32'h0,               3'b000,0,0,1,32'h0,32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].w, vecs[i].sel, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
            cyc();
            check($sformatf("vec%0d_psel", i), Pselx, vecs[i].e_psel);
            check($sformatf("vec%0d_penable", i), Penable, vecs[i].e_pen);
            check($sformatf("vec%0d_pwrite", i), Pwrite, vecs[i].e_pwr);
            check($sformatf("vec%0d_hready", i), Hreadyout, vecs[i].e_rdy);
            check($sformatf("vec%0d_paddr", i), Paddr, vecs[i].e_paddr);
            check($sformatf("vec%0d_pwdata", i), Pwdata, vecs[i].e_pwdata);
            check($sformatf("vec%0d_hrdata", i), Hrdata, vecs[i].rdata);
        end

        // Random isolated reads, writes and write pairs against a transfer queue
        mon_en = 1'b1;
        for (int n = 0; n < 80; n++) begin
            s = rsel(); a = $urandom; d = $urandom; r = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    x.sel = s; x.addr = a; x.data = 32'h0; x.rdata = r; x.wr = 1'b0;
                    exp_q.push_back(x);
                    drive(0, 1, 0, s, a, $urandom, r); cyc();
                    idle(3, r);
                end
                1: begin
                    x.sel = s; x.addr = a; x.data = d; x.rdata = r; x.wr = 1'b1;
                    exp_q.push_back(x);
                    drive(0, 1, 1, s, a, $urandom, r); cyc();
                    drive(0, 0, 0, 3'b000, $urandom, d, r); cyc();
                    idle(3, r);
                end
                default: begin
                    s2 = rsel(); a2 = $urandom; d2 = $urandom;
                    x.sel = s; x.addr = a; x.data = d; x.rdata = r; x.wr = 1'b1;
                    exp_q.push_back(x);
                    x.sel = s2; x.addr = a2; x.data = d2;
                    exp_q.push_back(x);
                    drive(0, 1, 1, s, a, $urandom, r);   cyc();
                    drive(0, 1, 1, s2, a2, d, r);        cyc();
                    drive(0, 0, 1, s2, a2, d2, r);       cyc();
                    idle(4, r);
                end
            endcase
            check("drain", exp_q.size(), 0);
            exp_q.delete();
        end
        mon_en = 1'b0;

        // Unconstrained traffic with occasional reset: APB protocol rules
        p_psel = Pselx; p_paddr = Paddr; p_pwdata = Pwdata; p_pwrite = Pwrite;
        p_setup = (Pselx != 3'b000) && !Penable;
        for (int n = 0; n < 1000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 3) == 0) ? 3'b000 : rsel();
            drive(rst, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, s, $urandom, $urandom, $urandom);
            cyc();
            if (rst) begin
                check("rnd_rst_psel", Pselx, 3'b000);
                check("rnd_rst_penable", Penable, 1'b0);
                check("rnd_rst_hready", Hreadyout, 1'b1);
                check("rnd_rst_paddr", Paddr, 32'h0);
                check("rnd_rst_pwdata", Pwdata, 32'h0);
                check("rnd_rst_pwrite", Pwrite, 1'b0);
            end else begin
                check("rnd_onehot0", $onehot0(Pselx), 1'b1);
                if (Penable) begin
                    check("rnd_en_after_setup", p_setup, 1'b1);
                    check("rnd_en_sel_nonzero", Pselx != 3'b000, 1'b1);
                    check("rnd_en_psel", Pselx, p_psel);
                    check("rnd_en_paddr", Paddr, p_paddr);
                    check("rnd_en_pwrite", Pwrite, p_pwrite);
                    check("rnd_en_pwdata", Pwdata, p_pwdata);
                end
                if (p_setup) check("rnd_setup_then_enable", Penable, 1'b1);
            end
            check("rnd_hready", Hreadyout, !((Pselx != 3'b000) && !Penable));
            check("rnd_hrdata", Hrdata, Prdata);
            p_psel = Pselx; p_paddr = Paddr; p_pwdata = Pwdata; p_pwrite = Pwrite;
            p_setup = (Pselx != 3'b000) && !Penable;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
